// File: rtl/bounce_shift_register.sv
// bounce_shift_register
//   WIDTH-bit LED pattern register with hold, rotate, end-to-end bounce and
//   parallel load. A built-in prescaler lets the pattern advance once every
//   DIV+1 enabled clock cycles.
//
// Ports
//   CP    in  1      clock, rising edge
//   CR    in  1      synchronous active-low reset
//   EN    in  1      step/prescaler enable (load ignores it)
//   S     in  2      mode: 00 hold, 01 rotate, 10 bounce, 11 load
//   DIV   in  DIV_W  step period minus one, in enabled cycles
//   D     in  WIDTH  parallel load data
//   Q     out WIDTH  pattern register
//   DIR   out 1      1 = shift toward MSB, 0 = toward LSB
//   STEP  out 1      pulse in the cycle Q first shows a shifted value
//   WRAP  out 1      pulse in the cycle DIR first shows a reversed value
module bounce_shift_register #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIV_W   = 4,
  parameter int unsigned RST_VAL = 1
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             EN,
  input  logic [1:0]       S,
  input  logic [DIV_W-1:0] DIV,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             DIR,
  output logic             STEP,
  output logic             WRAP
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] shifted;
  logic             step_fire;
  logic             at_end;

  // Both directions are rotates so no lit bit is ever lost.
  assign shifted = dir_q ? {q_q[WIDTH-2:0], q_q[WIDTH-1]}
                         : {q_q[0], q_q[WIDTH-1:1]};

  // ">=" rather than "==" so lowering DIV below the running count steps at
  // once instead of waiting for the counter to wrap.
  assign step_fire = (cnt_q >= DIV);

  // The pattern has reached the end it is travelling toward.
  assign at_end = dir_q ? shifted[WIDTH-1] : shifted[0];

  always_comb begin
    q_d    = q_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    wrap_d = 1'b0;

    unique case (S)
      MODE_LOAD: begin
        q_d   = D;
        cnt_d = '0;
        dir_d = 1'b1;
      end
      MODE_ROTATE, MODE_BOUNCE: begin
        if (EN) begin
          if (step_fire) begin
            cnt_d  = '0;
            q_d    = shifted;
            step_d = 1'b1;
            // Reverse on the same edge the end LED lights, so it is shown
            // for exactly one step period before the pattern heads back.
            if (S == MODE_BOUNCE && at_end) begin
              dir_d  = ~dir_q;
              wrap_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MODE_HOLD: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CP) begin
    if (!CR) begin
      q_q    <= WIDTH'(RST_VAL);
      dir_q  <= 1'b1;
      cnt_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign DIR  = dir_q;
  assign STEP = step_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_bounce_shift_register.sv
// Directed bench for bounce_shift_register (WIDTH=8, DIV_W=4, RST_VAL=1).
module tb_bounce_shift_register;

  logic       CP;
  logic       CR;
  logic       EN;
  logic [1:0] S;
  logic [3:0] DIV;
  logic [7:0] D;
  logic [7:0] Q;
  logic       DIR;
  logic       STEP;
  logic       WRAP;

  int n_checks;
  int n_errors;

  bounce_shift_register #(
    .WIDTH  (8),
    .DIV_W  (4),
    .RST_VAL(1)
  ) dut (
    .CP  (CP),
    .CR  (CR),
    .EN  (EN),
    .S   (S),
    .DIV (DIV),
    .D   (D),
    .Q   (Q),
    .DIR (DIR),
    .STEP(STEP),
    .WRAP(WRAP)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] eq, input logic edir,
                              input logic estep, input logic ewrap);
    $display("t=%0t %s: Q=%02h DIR=%0b STEP=%0b WRAP=%0b", $time, tag, Q, DIR, STEP, WRAP);
    check({tag, ".Q"},    32'(Q),    32'(eq));
    check({tag, ".DIR"},  32'(DIR),  32'(edir));
    check({tag, ".STEP"}, 32'(STEP), 32'(estep));
    check({tag, ".WRAP"}, 32'(WRAP), 32'(ewrap));
  endtask

  task automatic load(input logic [7:0] val);
    S = 2'b11;
    D = val;
    tick();
  endtask

  // Bounce sequence from reset with DIV=0.
  logic [7:0] b_q   [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic       b_dir [15] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  logic       b_wrap[15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};

  // Rotate with DIV=3: value after each tick 1..8.
  logic [7:0] r_q   [8] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04};
  logic       r_step[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  // EN toggling 1,0,1,0.. with DIV=1.
  logic [7:0] e_q   [8] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04};
  logic       e_step[8] = '{0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    n_checks = 0;
    n_errors = 0;
    CR  = 1'b0;
    EN  = 1'b1;
    S   = 2'b10;
    DIV = 4'd0;
    D   = 8'h00;

    // Reset state.
    tick();
    expect_state("reset", 8'h01, 1'b1, 1'b0, 1'b0);

    // Bounce end to end, DIV=0.
    CR = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      expect_state($sformatf("bounce%0d", i), b_q[i], b_dir[i], 1'b1, b_wrap[i]);
    end

    // Rotate with DIV=3 from a fresh load of 01.
    load(8'h01);
    expect_state("load01", 8'h01, 1'b1, 1'b0, 1'b0);
    S   = 2'b01;
    DIV = 4'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_state($sformatf("rot%0d", i), r_q[i], 1'b1, r_step[i], 1'b0);
    end

    // Load mid-count with EN=0, then confirm cnt was cleared.
    tick();
    tick();                       // cnt now 2, Q still 04
    EN = 1'b0;
    load(8'hA5);
    expect_state("loadA5", 8'hA5, 1'b1, 1'b0, 1'b0);
    EN  = 1'b1;
    S   = 2'b01;
    DIV = 4'd1;
    tick();
    expect_state("cnt_clr", 8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("rotA5", 8'h4B, 1'b1, 1'b1, 1'b0);

    // Bounce from C0 toward MSB.
    load(8'hC0);
    S   = 2'b10;
    DIV = 4'd0;
    tick();
    expect_state("bC0_a", 8'h81, 1'b0, 1'b1, 1'b1);
    tick();
    expect_state("bC0_b", 8'hC0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_state("bC0_c", 8'h60, 1'b0, 1'b1, 1'b0);

    // Reset mid-bounce with DIR=0 and cnt=2; glitch between edges is ignored.
    DIV = 4'd5;
    tick();
    CR = 1'b0;
    #2;
    CR = 1'b1;
    tick();
    expect_state("glitch", 8'h60, 1'b0, 1'b0, 1'b0);
    CR = 1'b0;
    tick();
    expect_state("rst_mid", 8'h01, 1'b1, 1'b0, 1'b0);
    CR  = 1'b1;
    DIV = 4'd1;
    tick();
    expect_state("rst_cnt0", 8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("rst_step", 8'h02, 1'b1, 1'b1, 1'b0);

    // Reset beats load.
    CR = 1'b0;
    S  = 2'b11;
    D  = 8'hFF;
    tick();
    expect_state("rst_load", 8'h01, 1'b1, 1'b0, 1'b0);
    CR = 1'b1;

    // EN toggling with DIV=1: one step per two enabled cycles.
    S   = 2'b01;
    DIV = 4'd1;
    for (int i = 0; i < 8; i++) begin
      EN = (i % 2 == 0);
      tick();
      expect_state($sformatf("en%0d", i), e_q[i], 1'b1, e_step[i], 1'b0);
    end

    // Hold freezes cnt at 1; the first rotate cycle afterwards steps.
    EN = 1'b1;
    tick();
    expect_state("pre_hold", 8'h04, 1'b1, 1'b0, 1'b0);
    S = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("hold%0d", i), 8'h04, 1'b1, 1'b0, 1'b0);
    end
    S = 2'b01;
    tick();
    expect_state("post_hold", 8'h08, 1'b1, 1'b1, 1'b0);

    // Lowering DIV below the running count steps on the next cycle.
    DIV = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("div7_%0d", i), 8'h08, 1'b1, 1'b0, 1'b0);
    end
    DIV = 4'd1;
    tick();
    expect_state("div_lower", 8'h10, 1'b1, 1'b1, 1'b0);

    // Bounce corner patterns: all zeros and all ones.
    load(8'h00);
    S   = 2'b10;
    DIV = 4'd0;
    tick();
    expect_state("zero", 8'h00, 1'b1, 1'b1, 1'b0);
    load(8'hFF);
    S = 2'b10;
    tick();
    expect_state("ones_a", 8'hFF, 1'b0, 1'b1, 1'b1);
    tick();
    expect_state("ones_b", 8'hFF, 1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
